// File: rtl/i2c_txn_arbiter_if.sv
// i2c_txn_arbiter_if
//   Bundles the requester-side and engine-side signals of the I2C
//   transaction arbiter.
//   master : the arbiter view (requests/engine status in, pulses/commands out)
//   slave  : the environment view (requesters plus bit engine)
//   Requester 0 is the APB register side, requester 1 the autonomous poller.
interface i2c_txn_arbiter_if #(
   parameter int unsigned LEN_W = 4
);
   logic             req_0,         req_1;
   logic [6:0]       addr_0,        addr_1;
   logic             rw_0,          rw_1;
   logic [LEN_W-1:0] len_0,         len_1;
   logic             rs_0,          rs_1;
   logic [7:0]       wdata_0,       wdata_1;
   logic             wdata_ack_0,   wdata_ack_1;
   logic [7:0]       rdata;
   logic             rdata_valid_0, rdata_valid_1;
   logic             done_0,        done_1;
   logic             nack_0,        nack_1;
   logic [1:0]       grant;
   logic             busy;
   logic             eng_cmd_valid;
   logic [2:0]       eng_cmd;
   logic [7:0]       eng_wdata;
   logic             eng_cmd_ready;
   logic             eng_done;
   logic [7:0]       eng_rdata;
   logic             eng_nack;

   modport master (
      input  req_0, req_1, addr_0, addr_1, rw_0, rw_1, len_0, len_1,
             rs_0, rs_1, wdata_0, wdata_1,
      output wdata_ack_0, wdata_ack_1, rdata, rdata_valid_0, rdata_valid_1,
             done_0, done_1, nack_0, nack_1, grant, busy,
      output eng_cmd_valid, eng_cmd, eng_wdata,
      input  eng_cmd_ready, eng_done, eng_rdata, eng_nack
   );

   modport slave (
      output req_0, req_1, addr_0, addr_1, rw_0, rw_1, len_0, len_1,
             rs_0, rs_1, wdata_0, wdata_1,
      input  wdata_ack_0, wdata_ack_1, rdata, rdata_valid_0, rdata_valid_1,
             done_0, done_1, nack_0, nack_1, grant, busy,
      input  eng_cmd_valid, eng_cmd, eng_wdata,
      output eng_cmd_ready, eng_done, eng_rdata, eng_nack
   );
endinterface

// File: rtl/i2c_txn_arbiter.sv
// i2c_txn_arbiter
//   Shares one byte-level I2C master engine between two requesters.
//   Round-robin arbitration, then sequences START / address / data bytes /
//   STOP (or repeated START with the grant retained in HOLD).
// Ports:
//   clk    system clock
//   rst_n  synchronous active-low reset (aborts without issuing STOP)
//   bus    i2c_txn_arbiter_if.master: requester fields and pulses,
//          grant/busy, engine command/response handshake
module i2c_txn_arbiter #(
   parameter int unsigned LEN_W = 4
) (
   input logic               clk,
   input logic               rst_n,
   i2c_txn_arbiter_if.master bus
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_ARB   = 3'd1;
   localparam logic [2:0] S_START = 3'd2;
   localparam logic [2:0] S_ADDR  = 3'd3;
   localparam logic [2:0] S_WDATA = 3'd4;
   localparam logic [2:0] S_RDATA = 3'd5;
   localparam logic [2:0] S_STOP  = 3'd6;
   localparam logic [2:0] S_HOLD  = 3'd7;

   localparam logic [2:0] C_START  = 3'd0;
   localparam logic [2:0] C_RSTART = 3'd1;
   localparam logic [2:0] C_WRITE  = 3'd2;
   localparam logic [2:0] C_RACK   = 3'd3;
   localparam logic [2:0] C_RNACK  = 3'd4;
   localparam logic [2:0] C_STOP   = 3'd5;

   logic [2:0]       state_q,  state_d;
   logic [1:0]       grant_q,  grant_d;
   logic             busy_q,   busy_d;
   logic             last_q,   last_d;    // index of last requester served
   logic             owner_q,  owner_d;
   logic [6:0]       addr_q,   addr_d;
   logic             rw_q,     rw_d;
   logic [LEN_W-1:0] len_q,    len_d;
   logic             rs_q,     rs_d;
   logic [LEN_W-1:0] cnt_q,    cnt_d;
   logic             nack_q,   nack_d;    // transaction saw a NACK
   logic             vld_q,    vld_d;
   logic [2:0]       cmd_q,    cmd_d;
   logic [7:0]       wd_q,     wd_d;
   logic             outst_q,  outst_d;   // command accepted, awaiting eng_done
   logic [7:0]       rdata_q,  rdata_d;
   logic [1:0]       rvld_q,   rvld_d;
   logic [1:0]       done_q,   done_d;
   logic [1:0]       nacko_q,  nacko_d;

   logic             accept, fin;
   logic             arb_pick, lsel;
   logic [6:0]       sel_addr;
   logic             sel_rw, sel_rs;
   logic [LEN_W-1:0] sel_len, cnt_dec;
   logic [7:0]       own_wdata;
   logic             own_req;
   logic             issue, go_end;
   logic [2:0]       issue_cmd;
   logic [7:0]       issue_wd;

   assign accept   = vld_q & bus.eng_cmd_ready;
   assign fin      = outst_q & bus.eng_done;   // stray eng_done is ignored
   assign arb_pick = (bus.req_0 & bus.req_1) ? ~last_q : bus.req_1;
   // Fields are latched either at arbitration or, in HOLD, from the owner.
   assign lsel     = (state_q == S_HOLD) ? owner_q : arb_pick;
   assign cnt_dec  = (cnt_q != '0) ? cnt_q - LEN_W'(1) : cnt_q;

   always_comb begin
      sel_addr  = lsel ? bus.addr_1 : bus.addr_0;
      sel_rw    = lsel ? bus.rw_1   : bus.rw_0;
      sel_len   = lsel ? bus.len_1  : bus.len_0;
      sel_rs    = lsel ? bus.rs_1   : bus.rs_0;
      own_wdata = owner_q ? bus.wdata_1 : bus.wdata_0;
      own_req   = owner_q ? bus.req_1   : bus.req_0;
   end

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      busy_d    = busy_q;
      last_d    = last_q;
      owner_d   = owner_q;
      addr_d    = addr_q;
      rw_d      = rw_q;
      len_d     = len_q;
      rs_d      = rs_q;
      cnt_d     = cnt_q;
      nack_d    = nack_q;
      vld_d     = vld_q;
      cmd_d     = cmd_q;
      wd_d      = wd_q;
      outst_d   = outst_q;
      rdata_d   = rdata_q;
      rvld_d    = '0;
      done_d    = '0;
      nacko_d   = '0;
      issue     = 1'b0;
      issue_cmd = C_START;
      issue_wd  = '0;
      go_end    = 1'b0;

      if (accept) begin
         vld_d   = 1'b0;
         outst_d = 1'b1;
      end
      if (fin) outst_d = 1'b0;

      case (state_q)
         S_IDLE: if (bus.req_0 | bus.req_1) state_d = S_ARB;
         S_ARB: begin
            if (bus.req_0 | bus.req_1) begin
               owner_d   = arb_pick;
               grant_d   = arb_pick ? 2'b10 : 2'b01;
               busy_d    = 1'b1;
               addr_d    = sel_addr;
               rw_d      = sel_rw;
               len_d     = sel_len;
               rs_d      = sel_rs;
               cnt_d     = sel_len;
               nack_d    = 1'b0;
               state_d   = S_START;
               issue     = 1'b1;
               issue_cmd = C_START;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_START: if (fin) begin
            state_d   = S_ADDR;
            issue     = 1'b1;
            issue_cmd = C_WRITE;
            issue_wd  = {addr_q, rw_q};
         end
         S_ADDR: if (fin) begin
            if (bus.eng_nack) begin
               nack_d    = 1'b1;
               state_d   = S_STOP;
               issue     = 1'b1;
               issue_cmd = C_STOP;
            end else if (len_q == '0) begin
               go_end = 1'b1;
            end else if (!rw_q) begin
               state_d   = S_WDATA;
               issue     = 1'b1;
               issue_cmd = C_WRITE;
               issue_wd  = own_wdata;
            end else begin
               state_d   = S_RDATA;
               issue     = 1'b1;
               issue_cmd = (cnt_q > LEN_W'(1)) ? C_RACK : C_RNACK;
            end
         end
         S_WDATA: if (fin) begin
            cnt_d = cnt_dec;
            if (bus.eng_nack) begin
               nack_d    = 1'b1;
               state_d   = S_STOP;
               issue     = 1'b1;
               issue_cmd = C_STOP;
            end else if (cnt_dec == '0) begin
               go_end = 1'b1;
            end else begin
               issue     = 1'b1;
               issue_cmd = C_WRITE;
               issue_wd  = own_wdata;
            end
         end
         S_RDATA: if (fin) begin
            rdata_d         = bus.eng_rdata;
            rvld_d[owner_q] = 1'b1;
            cnt_d           = cnt_dec;
            if (cnt_dec == '0) begin
               go_end = 1'b1;
            end else begin
               issue     = 1'b1;
               issue_cmd = (cnt_dec > LEN_W'(1)) ? C_RACK : C_RNACK;
            end
         end
         S_STOP: if (fin) begin
            done_d[owner_q]  = 1'b1;
            nacko_d[owner_q] = nack_q;
            grant_d          = '0;
            busy_d           = 1'b0;
            last_d           = owner_q;
            state_d          = S_IDLE;
         end
         S_HOLD: begin
            // The other requester cannot break in until STOP is issued.
            if (own_req) begin
               addr_d    = sel_addr;
               rw_d      = sel_rw;
               len_d     = sel_len;
               rs_d      = sel_rs;
               cnt_d     = sel_len;
               nack_d    = 1'b0;
               state_d   = S_START;
               issue     = 1'b1;
               issue_cmd = C_RSTART;
            end else begin
               state_d   = S_STOP;
               issue     = 1'b1;
               issue_cmd = C_STOP;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Clean end of data phase: repeated START keeps the bus, else STOP.
      if (go_end) begin
         if (rs_q) begin
            done_d[owner_q] = 1'b1;
            state_d         = S_HOLD;
         end else begin
            state_d   = S_STOP;
            issue     = 1'b1;
            issue_cmd = C_STOP;
         end
      end

      if (issue) begin
         vld_d = 1'b1;
         cmd_d = issue_cmd;
         wd_d  = issue_wd;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         grant_q <= '0;
         busy_q  <= 1'b0;
         last_q  <= 1'b1;
         owner_q <= 1'b0;
         addr_q  <= '0;
         rw_q    <= 1'b0;
         len_q   <= '0;
         rs_q    <= 1'b0;
         cnt_q   <= '0;
         nack_q  <= 1'b0;
         vld_q   <= 1'b0;
         cmd_q   <= '0;
         wd_q    <= '0;
         outst_q <= 1'b0;
         rdata_q <= '0;
         rvld_q  <= '0;
         done_q  <= '0;
         nacko_q <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         busy_q  <= busy_d;
         last_q  <= last_d;
         owner_q <= owner_d;
         addr_q  <= addr_d;
         rw_q    <= rw_d;
         len_q   <= len_d;
         rs_q    <= rs_d;
         cnt_q   <= cnt_d;
         nack_q  <= nack_d;
         vld_q   <= vld_d;
         cmd_q   <= cmd_d;
         wd_q    <= wd_d;
         outst_q <= outst_d;
         rdata_q <= rdata_d;
         rvld_q  <= rvld_d;
         done_q  <= done_d;
         nacko_q <= nacko_d;
      end
   end

   // wdata_ack is combinational on the accepting cycle so the requester's
   // next byte is already in place when the WRITE's eng_done arrives.
   assign bus.wdata_ack_0   = accept & (state_q == S_WDATA) & ~owner_q;
   assign bus.wdata_ack_1   = accept & (state_q == S_WDATA) &  owner_q;
   assign bus.rdata         = rdata_q;
   assign bus.rdata_valid_0 = rvld_q[0];
   assign bus.rdata_valid_1 = rvld_q[1];
   assign bus.done_0        = done_q[0];
   assign bus.done_1        = done_q[1];
   assign bus.nack_0        = nacko_q[0];
   assign bus.nack_1        = nacko_q[1];
   assign bus.grant         = grant_q;
   assign bus.busy          = busy_q;
   assign bus.eng_cmd_valid = vld_q;
   assign bus.eng_cmd       = cmd_q;
   assign bus.eng_wdata     = wd_q;

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// tb_i2c_txn_arbiter
//   Directed bench for i2c_txn_arbiter: a behavioural byte engine with
//   scripted ACK/NACK and read data, requester models for wdata, and
//   hand-written expected command streams and status pulses.
module tb_i2c_txn_arbiter;
   localparam int unsigned LEN_W = 4;

   localparam logic [2:0] K_START  = 3'd0;
   localparam logic [2:0] K_RSTART = 3'd1;
   localparam logic [2:0] K_WRITE  = 3'd2;
   localparam logic [2:0] K_RACK   = 3'd3;
   localparam logic [2:0] K_RNACK  = 3'd4;
   localparam logic [2:0] K_STOP   = 3'd5;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   i2c_txn_arbiter_if #(.LEN_W(LEN_W)) bus ();
   i2c_txn_arbiter #(.LEN_W(LEN_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // ---------------- engine model ----------------
   logic [10:0] cmd_log[$];
   logic [10:0] exp_cmds[$];
   logic        nack_rsp[$];
   logic [7:0]  rd_rsp[$];
   int          stall_cfg = 0;

   initial begin
      int         es;
      int         stall;
      logic [2:0] cap_cmd, acc_cmd;
      logic [7:0] cap_wd, acc_wd;
      es = 0; stall = 0;
      cap_cmd = '0; cap_wd = '0; acc_cmd = '0; acc_wd = '0;
      bus.eng_cmd_ready = 1'b0;
      bus.eng_done      = 1'b0;
      bus.eng_rdata     = '0;
      bus.eng_nack      = 1'b0;
      forever begin
         @(negedge clk);
         bus.eng_cmd_ready = 1'b0;
         bus.eng_done      = 1'b0;
         bus.eng_rdata     = '0;
         bus.eng_nack      = 1'b0;
         if (!rst_n) begin
            es = 0; stall = 0;
         end else begin
            case (es)
               0: if (bus.eng_cmd_valid) begin
                  if (stall == 0) begin
                     cap_cmd = bus.eng_cmd;
                     cap_wd  = bus.eng_wdata;
                  end
                  if (stall < stall_cfg) begin
                     stall++;
                  end else begin
                     if (stall_cfg > 0)
                        check_eq("cmd_stable", {21'd0, bus.eng_cmd, bus.eng_wdata},
                                 {21'd0, cap_cmd, cap_wd});
                     bus.eng_cmd_ready = 1'b1;
                     acc_cmd = bus.eng_cmd;
                     acc_wd  = (bus.eng_cmd == K_WRITE) ? bus.eng_wdata : 8'h00;
                     stall   = 0;
                     es      = 1;
                  end
               end
               1: begin
                  cmd_log.push_back({acc_cmd, acc_wd});
                  check_eq("valid_drop", {31'd0, bus.eng_cmd_valid}, 32'd0);
                  es = 2;
               end
               default: begin
                  bus.eng_done = 1'b1;
                  if (acc_cmd == K_WRITE && nack_rsp.size() > 0) bus.eng_nack = nack_rsp.pop_front();
                  if ((acc_cmd == K_RACK || acc_cmd == K_RNACK) && rd_rsp.size() > 0)
                     bus.eng_rdata = rd_rsp.pop_front();
                  es = 0;
               end
            endcase
         end
      end
   end

   // ---------------- monitor / wdata suppliers ----------------
   logic [1:0] done_log[$];
   logic [8:0] rd_log[$];
   logic [1:0] grant_log[$];
   logic [1:0] grant_prev = '0;
   logic [7:0] wq0[$], wq1[$];
   int         ack0 = 0, ack1 = 0;

   initial begin
      bus.wdata_0 = '0;
      bus.wdata_1 = '0;
      forever begin
         @(negedge clk);
         #1;
         if (bus.done_0) done_log.push_back({1'b0, bus.nack_0});
         if (bus.done_1) done_log.push_back({1'b1, bus.nack_1});
         if (bus.rdata_valid_0) rd_log.push_back({1'b0, bus.rdata});
         if (bus.rdata_valid_1) rd_log.push_back({1'b1, bus.rdata});
         if (bus.wdata_ack_0) begin ack0++; if (wq0.size() > 0) void'(wq0.pop_front()); end
         if (bus.wdata_ack_1) begin ack1++; if (wq1.size() > 0) void'(wq1.pop_front()); end
         bus.wdata_0 = (wq0.size() > 0) ? wq0[0] : 8'h00;
         bus.wdata_1 = (wq1.size() > 0) ? wq1[0] : 8'h00;
         if (bus.grant !== grant_prev) begin
            grant_log.push_back(bus.grant);
            grant_prev = bus.grant;
         end
      end
   end

   // ---------------- helpers ----------------
   task automatic wait_done(input int port, input string tag);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk); #2;
         if ((port == 0) ? bus.done_0 : bus.done_1) begin ok = 1'b1; break; end
      end
      check_eq({tag, "_done_seen"}, {31'd0, ok}, 32'd1);
   endtask

   task automatic check_cmds(input string tag);
      check_eq({tag, "_ncmd"}, cmd_log.size(), exp_cmds.size());
      foreach (exp_cmds[i])
         if (i < cmd_log.size())
            check_eq($sformatf("%s_cmd%0d", tag, i), {21'd0, cmd_log[i]}, {21'd0, exp_cmds[i]});
      cmd_log.delete();
      exp_cmds.delete();
   endtask

   task automatic clear_logs();
      cmd_log.delete(); exp_cmds.delete(); done_log.delete(); rd_log.delete();
      ack0 = 0; ack1 = 0;
   endtask

   task automatic set_req0(input logic [6:0] a, input logic rw, input logic [LEN_W-1:0] l, input logic rs);
      bus.addr_0 = a; bus.rw_0 = rw; bus.len_0 = l; bus.rs_0 = rs; bus.req_0 = 1'b1;
   endtask

   task automatic set_req1(input logic [6:0] a, input logic rw, input logic [LEN_W-1:0] l, input logic rs);
      bus.addr_1 = a; bus.rw_1 = rw; bus.len_1 = l; bus.rs_1 = rs; bus.req_1 = 1'b1;
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk); #2;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------- directed sequence ----------------
   initial begin
      bit ok;
      bus.req_0 = 0; bus.addr_0 = '0; bus.rw_0 = 0; bus.len_0 = '0; bus.rs_0 = 0;
      bus.req_1 = 0; bus.addr_1 = '0; bus.rw_1 = 0; bus.len_1 = '0; bus.rs_1 = 0;
      repeat (3) @(negedge clk);
      #2;
      check_eq("rst_grant", {30'd0, bus.grant}, 32'd0);
      check_eq("rst_busy",  {31'd0, bus.busy}, 32'd0);
      check_eq("rst_valid", {31'd0, bus.eng_cmd_valid}, 32'd0);
      check_eq("rst_cmd",   {29'd0, bus.eng_cmd}, 32'd0);
      check_eq("rst_wdata", {24'd0, bus.eng_wdata}, 32'd0);
      check_eq("rst_rdata", {24'd0, bus.rdata}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk); #2;

      // Write, two bytes, engine stalls ready by one cycle
      stall_cfg = 1;
      wq0.push_back(8'hA5); wq0.push_back(8'h3C);
      @(negedge clk); #2;
      set_req0(7'h50, 1'b0, 4'd2, 1'b0);
      @(negedge clk); #2;
      check_eq("wr_arb_grant", {30'd0, bus.grant}, 32'd0);
      @(negedge clk); #2;
      check_eq("wr_grant", {30'd0, bus.grant}, 32'd1);
      check_eq("wr_busy",  {31'd0, bus.busy}, 32'd1);
      check_eq("wr_valid", {31'd0, bus.eng_cmd_valid}, 32'd1);
      check_eq("wr_start", {29'd0, bus.eng_cmd}, {29'd0, K_START});
      wait_done(0, "wr");
      check_eq("wr_nack", {31'd0, bus.nack_0}, 32'd0);
      check_eq("wr_grant_clr", {30'd0, bus.grant}, 32'd0);
      check_eq("wr_busy_clr", {31'd0, bus.busy}, 32'd0);
      bus.req_0 = 1'b0;
      exp_cmds = '{{K_START, 8'h00}, {K_WRITE, 8'hA0}, {K_WRITE, 8'hA5},
                   {K_WRITE, 8'h3C}, {K_STOP, 8'h00}};
      check_cmds("wr");
      check_eq("wr_acks", ack0, 32'd2);
      check_eq("wr_ndone", done_log.size(), 32'd1);
      stall_cfg = 0;
      clear_logs();

      // Address NACK on a read from port 1
      nack_rsp.push_back(1'b1);
      set_req1(7'h22, 1'b1, 4'd3, 1'b0);
      wait_done(1, "an");
      check_eq("an_nack", {31'd0, bus.nack_1}, 32'd1);
      bus.req_1 = 1'b0;
      exp_cmds = '{{K_START, 8'h00}, {K_WRITE, 8'h45}, {K_STOP, 8'h00}};
      check_cmds("an");
      check_eq("an_no_rdata", rd_log.size(), 32'd0);
      clear_logs();

      // Reset during the data phase of a read
      rd_rsp = '{8'h11, 8'h22, 8'h33};
      set_req0(7'h50, 1'b1, 4'd3, 1'b0);
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk); #2;
         if (bus.rdata_valid_0) begin ok = 1'b1; break; end
      end
      check_eq("rr_first_byte_seen", {31'd0, ok}, 32'd1);
      check_eq("rr_first_byte", {24'd0, bus.rdata}, 32'h11);
      rst_n = 1'b0;
      @(negedge clk); #2;
      check_eq("rr_grant", {30'd0, bus.grant}, 32'd0);
      check_eq("rr_busy",  {31'd0, bus.busy}, 32'd0);
      check_eq("rr_valid", {31'd0, bus.eng_cmd_valid}, 32'd0);
      check_eq("rr_cmd",   {29'd0, bus.eng_cmd}, 32'd0);
      check_eq("rr_rdata", {24'd0, bus.rdata}, 32'd0);
      bus.req_0 = 1'b0;
      @(negedge clk);
      #2 rst_n = 1'b1;
      repeat (4) @(negedge clk);
      #2;
      check_eq("rr_no_done", done_log.size(), 32'd0);
      rd_rsp.delete(); nack_rsp.delete();
      clear_logs();

      // Fresh three-byte read after the reset
      rd_rsp = '{8'h11, 8'h22, 8'h33};
      set_req0(7'h50, 1'b1, 4'd3, 1'b0);
      wait_done(0, "rd");
      check_eq("rd_nack", {31'd0, bus.nack_0}, 32'd0);
      bus.req_0 = 1'b0;
      exp_cmds = '{{K_START, 8'h00}, {K_WRITE, 8'hA1}, {K_RACK, 8'h00},
                   {K_RACK, 8'h00}, {K_RNACK, 8'h00}, {K_STOP, 8'h00}};
      check_cmds("rd");
      check_eq("rd_nbytes", rd_log.size(), 32'd3);
      if (rd_log.size() == 3) begin
         check_eq("rd_b0", {23'd0, rd_log[0]}, {23'd0, 9'h011});
         check_eq("rd_b1", {23'd0, rd_log[1]}, {23'd0, 9'h022});
         check_eq("rd_b2", {23'd0, rd_log[2]}, {23'd0, 9'h033});
      end
      clear_logs();

      // Arbitration: ties after reset go 0 then 1, twice
      pulse_reset();
      for (int p = 0; p < 2; p++) begin
         set_req0(7'h10, 1'b0, 4'd0, 1'b0);
         set_req1(7'h20, 1'b0, 4'd0, 1'b0);
         wait_done(0, "tie_p0");
         bus.req_0 = 1'b0;
         wait_done(1, "tie_p1");
         bus.req_1 = 1'b0;
         check_eq($sformatf("tie%0d_ndone", p), done_log.size(), 32'd2);
         if (done_log.size() == 2) begin
            check_eq($sformatf("tie%0d_first", p),  {30'd0, done_log[0]}, 32'd0);
            check_eq($sformatf("tie%0d_second", p), {30'd0, done_log[1]}, 32'd2);
         end
         exp_cmds = '{{K_START, 8'h00}, {K_WRITE, 8'h20}, {K_STOP, 8'h00},
                      {K_START, 8'h00}, {K_WRITE, 8'h40}, {K_STOP, 8'h00}};
         check_cmds($sformatf("tie%0d", p));
         clear_logs();
      end
      // Port 0 alone, then a tie must favour port 1
      set_req0(7'h10, 1'b0, 4'd0, 1'b0);
      wait_done(0, "solo");
      bus.req_0 = 1'b0;
      clear_logs();
      set_req0(7'h10, 1'b0, 4'd0, 1'b0);
      set_req1(7'h20, 1'b0, 4'd0, 1'b0);
      wait_done(1, "alt_p1");
      bus.req_1 = 1'b0;
      wait_done(0, "alt_p0");
      bus.req_0 = 1'b0;
      check_eq("alt_ndone", done_log.size(), 32'd2);
      if (done_log.size() == 2) check_eq("alt_first", {30'd0, done_log[0]}, 32'd2);
      clear_logs();

      // Repeated START: write then read on port 0 while port 1 waits
      grant_log.delete();
      wq0.push_back(8'h77);
      @(negedge clk); #2;
      set_req0(7'h50, 1'b0, 4'd1, 1'b1);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk); #2;
         if (bus.grant == 2'b01) begin ok = 1'b1; break; end
      end
      check_eq("rs_granted", {31'd0, ok}, 32'd1);
      set_req1(7'h30, 1'b0, 4'd0, 1'b0);
      wait_done(0, "rs_a");
      check_eq("rs_a_nack", {31'd0, bus.nack_0}, 32'd0);
      check_eq("rs_hold_grant", {30'd0, bus.grant}, 32'd1);
      check_eq("rs_hold_busy", {31'd0, bus.busy}, 32'd1);
      rd_rsp.push_back(8'h5A);
      set_req0(7'h50, 1'b1, 4'd1, 1'b0);
      wait_done(0, "rs_b");
      bus.req_0 = 1'b0;
      wait_done(1, "rs_c");
      bus.req_1 = 1'b0;
      exp_cmds = '{{K_START, 8'h00}, {K_WRITE, 8'hA0}, {K_WRITE, 8'h77},
                   {K_RSTART, 8'h00}, {K_WRITE, 8'hA1}, {K_RNACK, 8'h00},
                   {K_STOP, 8'h00}, {K_START, 8'h00}, {K_WRITE, 8'h60},
                   {K_STOP, 8'h00}};
      check_cmds("rs");
      check_eq("rs_acks", ack0, 32'd1);
      check_eq("rs_ndone", done_log.size(), 32'd3);
      check_eq("rs_nrd", rd_log.size(), 32'd1);
      if (rd_log.size() == 1) check_eq("rs_rd", {23'd0, rd_log[0]}, {23'd0, 9'h05A});
      check_eq("rs_ngrant", grant_log.size(), 32'd4);
      if (grant_log.size() == 4) begin
         check_eq("rs_g0", {30'd0, grant_log[0]}, 32'd1);
         check_eq("rs_g1", {30'd0, grant_log[1]}, 32'd0);
         check_eq("rs_g2", {30'd0, grant_log[2]}, 32'd2);
         check_eq("rs_g3", {30'd0, grant_log[3]}, 32'd0);
      end

      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/i2c_txn_arbiter.md
# i2c_txn_arbiter

Transaction-level controller that shares one byte-level I2C master engine between two requesters (CPU/APB register side on port 0, autonomous poller on port 1). It arbitrates round-robin and sequences each granted transaction as START / address byte / data bytes / STOP or repeated START. It reports per-byte data and completion/NACK status back to the owner. It sits between the APB register file and the I2C bit engine that drives scl/sda.

## Interface

- LEN_W, 4, width of the transaction byte count (max LEN = 2^LEN_W−1)
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- req_0 / req_1  in  1  transaction request; held high and fields stable until matching done pulse
- addr_0 / addr_1  in  7  7-bit slave address
- rw_0 / rw_1  in  1  0 = write, 1 = read
- len_0 / len_1  in  LEN_W  data byte count; 0 = address-only probe
- rs_0 / rs_1  in  1  end with repeated START instead of STOP; grant retained
- wdata_0 / wdata_1  in  8  current write byte
- wdata_ack_0 / wdata_ack_1  out  1  one-cycle pulse: wdata consumed, present next byte
- rdata  out  8  last read byte (shared)
- rdata_valid_0 / rdata_valid_1  out  1  one-cycle pulse: rdata valid for that requester
- done_0 / done_1  out  1  one-cycle pulse: transaction finished
- nack_0 / nack_1  out  1  valid with done; 1 = slave NACKed address or a write byte
- grant  out  2  one-hot current owner, 00 when idle
- busy  out  1  bus owned (from grant until STOP completes)
- eng_cmd_valid  out  1  command to engine
- eng_cmd  out  3  0 START, 1 RSTART, 2 WRITE, 3 READ_ACK, 4 READ_NACK, 5 STOP
- eng_wdata  out  8  byte for WRITE
- eng_cmd_ready  in  1  engine accepts command when high with valid
- eng_done  in  1  one-cycle pulse: accepted command completed
- eng_rdata  in  8  read byte, valid with eng_done after READ_*
- eng_nack  in  1  valid with eng_done after WRITE; 1 = no ACK

## Operation

- States: IDLE, ARB, START, ADDR, WDATA, RDATA, STOP, HOLD.
- IDLE: any req high → ARB. ARB picks owner: one requester → it; both → the one not granted last. last_grant resets to 1 so port 0 wins the first tie. Sets grant, busy; latches addr/rw/len; byte_cnt ← len.
- START: issue START (or RSTART if entered from HOLD).
- ADDR: issue WRITE with eng_wdata = {addr, rw}. On eng_done: eng_nack=1 → STOP with nack flagged; len=0 → STOP; rw=0 → WDATA; rw=1 → RDATA.
- WDATA: issue WRITE with the owner's wdata; pulse wdata_ack_x when the command is accepted. On eng_done, byte_cnt−1. eng_nack=1 → STOP with nack flagged, remaining bytes skipped. byte_cnt=0 → end.
- RDATA: issue READ_ACK while byte_cnt>1, READ_NACK when byte_cnt=1. On eng_done, rdata ← eng_rdata; pulse rdata_valid_x; byte_cnt−1. byte_cnt=0 → end.
- End (no NACK): rs_x=0 → STOP. rs_x=1 → pulse done_x (nack=0), enter HOLD.
- STOP: issue STOP. On eng_done, pulse done_x/nack_x, clear grant and busy, update last_grant, go to IDLE. A NACK always ends with STOP, regardless of rs_x.
- HOLD: grant and busy stay set. Owner req high (new fields latched) → START issuing RSTART. Other requester is ignored while in HOLD. Owner req low for 1 cycle → STOP.
- A requester dropping req mid-transaction is ignored; the transaction completes.
- byte_cnt is LEN_W bits and never wraps: decrement only when >0.

## Timing

- Reset (synchronous, rst_n low at clk edge): state IDLE; all outputs 0 (grant=00, busy=0, eng_cmd_valid=0, eng_cmd=0, eng_wdata=0, rdata=0, all pulses 0); last_grant=1. Reset mid-transaction aborts with no STOP issued and no done; the engine is reset separately.
- req high at edge N → ARB at N+1 → grant/busy high and eng_cmd_valid=START at N+2.
- eng_cmd_valid stays high with cmd/wdata stable until the cycle eng_cmd_ready=1, then drops the next cycle. Only one command is outstanding.
- Next command asserted the cycle after eng_done, at the earliest.
- done_x/nack_x are asserted the cycle after STOP's eng_done, or after the last byte's eng_done for rs=1. grant clears the same cycle as done for STOP endings.
- eng_done without an outstanding command is ignored.

## Test plan

- Write: req_0, addr=0x50, rw=0, len=2, wdata 0xA5 then 0x3C, engine ACKs all → cmds START, WRITE 0xA0, WRITE 0xA5, WRITE 0x3C, STOP; two wdata_ack_0; done_0=1, nack_0=0.
- Address NACK: req_1 addr=0x22 rw=1 len=3, eng_nack=1 on address → START, WRITE 0x45, STOP; no rdata_valid; done_1 with nack_1=1.
- Read: addr=0x50 rw=1 len=3, engine returns 0x11, 0x22, 0x33 → READ_ACK, READ_ACK, READ_NACK; three rdata_valid pulses carrying those values; done with nack=0.
- Arbitration: req_0 and req_1 rise together, len=0 each → port 0 served first (START, WRITE, STOP), then port 1. A second simultaneous pair → port 1 is not favoured twice; the grant alternates.
- Repeated start: req_0 write len=1 rs=1, then req_0 read len=1 rs=0, with req_1 held high throughout → START…, done_0, RSTART…, STOP; grant stays 01 across both; req_1 is granted only after the STOP.
- Reset mid-read: assert rst_n=0 during RDATA → next cycle all outputs 0 and grant=00; no done pulse; a new request is then served normally from START.
